// File: rtl/display_pkg.sv
// Shared definitions for the register_display block.
//   state_t      : conversion FSM states (IDLE, SHIFT, DONE)
//   SEG_0..SEG_9 : seven-segment codes, active-low, bit order gfedcba (bit0 = a)
//   SEG_BLANK    : all segments off (active-low)
//   bcd_digits() : number of decimal digits needed for an unsigned binary width
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // ceil(width * log10(2)) in integer arithmetic; log10(2) ~= 0.30103.
    // For width = 32 this yields 10.
    function automatic int bcd_digits(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to seven-segment decoder.
//   digit      : BCD digit 0..9 (10..15 shown blank)
//   blank      : force all segments off
//   active_low : 1 = segment lit by driving 0, 0 = lit by driving 1
//   seg        : segments, bit order gfedcba (bit0 = a)
module bcd_to_seg7
    import display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       active_low,
    output logic [6:0] seg
);

    logic [6:0] code;

    // NOTE: every signal written in always_comb gets a default first so that
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        code = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    code = SEG_0;
                4'd1:    code = SEG_1;
                4'd2:    code = SEG_2;
                4'd3:    code = SEG_3;
                4'd4:    code = SEG_4;
                4'd5:    code = SEG_5;
                4'd6:    code = SEG_6;
                4'd7:    code = SEG_7;
                4'd8:    code = SEG_8;
                4'd9:    code = SEG_9;
                default: code = SEG_BLANK;
            endcase
        end
        seg = active_low ? code : ~code;
    end

endmodule

// File: rtl/register_display.sv
// Displays the register-file toDisplay value (register $31) in decimal on
// DIGITS static seven-segment displays.
//   clock    : system clock, rising edge
//   resetn   : asynchronous active-low reset
//   value    : binary value to display
//   seg      : segment bus, digit i at [7i+6:7i], bit order gfedcba
//   overflow : value does not fit in DIGITS decimal digits
//   busy     : conversion in progress
// A change of value starts a double-dabble conversion (one bit per clock);
// the result is committed in one step so the display never shows partial data.
module register_display
    import display_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int DIGITS         = 8,
    parameter bit BLANK_ZEROS    = 1'b1,
    parameter bit ACTIVE_LOW_SEG = 1'b1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [WIDTH-1:0]      value,
    output logic [DIGITS*7-1:0]   seg,
    output logic                  overflow,
    output logic                  busy
);

    localparam int BCD_W = bcd_digits(WIDTH);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t                 state;
    state_t                 state_next;
    logic [WIDTH-1:0]       last_value;
    logic [WIDTH-1:0]       shift_bin;
    logic [4*BCD_W-1:0]     bcd_acc;
    logic [4*BCD_W-1:0]     bcd_adj;
    logic [4*BCD_W-1:0]     bcd_res;
    logic [CNT_W-1:0]       count;
    logic                   busy_q;

    logic                   value_changed;
    assign value_changed = (value != last_value);

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (value_changed) state_next = ST_SHIFT;
            ST_SHIFT: if (count == '0)   state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Double-dabble datapath
    // ---------------------------------------------------------------
    // Add-3 correction applied to every nibble >= 5 before the shift.
    always_comb begin
        bcd_adj = bcd_acc;
        for (int i = 0; i < BCD_W; i++) begin
            if (bcd_acc[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_value <= '0;
            shift_bin  <= '0;
            bcd_acc    <= '0;
            bcd_res    <= '0;
            count      <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (value_changed) begin
                        shift_bin  <= value;
                        last_value <= value;
                        bcd_acc    <= '0;
                        count      <= CNT_W'(WIDTH - 1);
                        busy_q     <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    {bcd_acc, shift_bin} <= {bcd_adj, shift_bin} << 1;
                    count                <= count - 1'b1;
                end
                ST_DONE: begin
                    bcd_res <= bcd_acc;
                    busy_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy = busy_q;

    // ---------------------------------------------------------------
    // Display decode, driven only by bcd_res so outputs move only on
    // commit or reset. Digits beyond the converted range read as zero.
    // ---------------------------------------------------------------
    logic [3:0]        disp_digit [DIGITS];
    logic [DIGITS-1:0] blank;
    logic              lit_above;
    logic              ovf;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        if (i < BCD_W) begin : g_conv
            assign disp_digit[i] = bcd_res[4*i +: 4];
        end else begin : g_pad
            assign disp_digit[i] = 4'd0;
        end

        bcd_to_seg7 u_dec (
            .digit      (disp_digit[i]),
            .blank      (blank[i]),
            .active_low (ACTIVE_LOW_SEG),
            .seg        (seg[7*i +: 7])
        );
    end

    always_comb begin
        ovf = 1'b0;
        for (int i = DIGITS; i < BCD_W; i++) begin
            if (bcd_res[4*i +: 4] != 4'd0) ovf = 1'b1;
        end
    end

    // Walk from the most significant digit down: a digit stays lit once any
    // digit at or above it is nonzero. Overflow or disabled blanking lights all.
    always_comb begin
        blank     = '0;
        lit_above = ovf | ~BLANK_ZEROS;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lit_above = lit_above | (disp_digit[i] != 4'd0);
            blank[i]  = ~lit_above;
        end
    end

    assign overflow = ovf;

endmodule

// File: tb/tb_register_display.sv
// Self-checking bench for register_display with default parameters
// (WIDTH 32, DIGITS 8, leading-zero blanking, active-low segments).
module tb_register_display;

    localparam int WIDTH   = 32;
    localparam int DIGITS  = 8;
    localparam int LATENCY = WIDTH + 1;   // edges after the detecting edge

    logic                clock  = 1'b0;
    logic                resetn = 1'b0;
    logic [WIDTH-1:0]    value  = '0;
    logic [DIGITS*7-1:0] seg;
    logic                overflow;
    logic                busy;

    int errors = 0;
    int checks = 0;

    register_display #(
        .WIDTH          (WIDTH),
        .DIGITS         (DIGITS),
        .BLANK_ZEROS    (1'b1),
        .ACTIVE_LOW_SEG (1'b1)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .value    (value),
        .seg      (seg),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [6:0] code_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic exp_ovf(input longint unsigned v);
        return v >= 64'd100000000;
    endfunction

    function automatic logic [DIGITS*7-1:0] exp_seg(input longint unsigned v);
        logic [DIGITS*7-1:0] s;
        int                  d [DIGITS];
        logic                lit;
        longint unsigned     r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            d[i] = int'(r % 10);
            r    = r / 10;
        end
        lit = exp_ovf(v);
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (d[i] != 0) lit = 1'b1;
            s[7*i +: 7] = lit ? code_of(d[i]) : 7'b1111111;
        end
        s[6:0] = code_of(d[0]);
        return s;
    endfunction

    // Protocol model: a change seen while idle is displayed LATENCY edges
    // later; changes arriving during that window are ignored.
    logic            m_busy    = 1'b0;
    longint unsigned m_last    = 0;
    longint unsigned m_pending = 0;
    longint unsigned m_shown   = 0;
    int              m_left    = 0;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_busy = 1'b0; m_last = 0; m_pending = 0; m_shown = 0; m_left = 0;
        end else if (!m_busy) begin
            if (longint'(value) != m_last) begin
                m_last = value; m_pending = value; m_busy = 1'b1; m_left = LATENCY;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_busy  = 1'b0;
                m_shown = m_pending;
            end
        end
    end

    // Cycle-by-cycle comparison on the falling edge.
    always @(negedge clock) begin
        check("seg", 64'(seg), 64'(exp_seg(m_shown)));
        check("overflow", 64'(overflow), 64'(exp_ovf(m_shown)));
        check("busy", 64'(busy), 64'(m_busy));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    localparam logic [6:0] B = 7'b1111111;

    initial begin : stim
        logic done;

        // 1. reset held with value 0
        tick(100);
        check("reset_seg", 64'(seg), 64'({B, B, B, B, B, B, B, 7'b1000000}));
        check("reset_ovf", 64'(overflow), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);

        // value 0 after release: nothing to convert
        resetn = 1'b1;
        tick(5);
        check("zero_no_busy", 64'(busy), 64'd0);

        // 2. 1234
        value = 32'd1234;
        tick(1);
        check("busy_rise", 64'(busy), 64'd1);
        tick(LATENCY - 1);
        check("busy_mid", 64'(busy), 64'd1);
        tick(1);
        check("seg_1234", 64'(seg),
              64'({B, B, B, B, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}));
        check("busy_fall", 64'(busy), 64'd0);

        // 3. exactly 10^8
        value = 32'd100000000;
        tick(LATENCY + 1);
        check("ovf_1e8", 64'(overflow), 64'd1);
        check("seg_1e8", 64'(seg), 64'({8{7'b1000000}}));

        // boundary: 10^8 - 1 fits
        value = 32'd99999999;
        tick(LATENCY + 1);
        check("ovf_99999999", 64'(overflow), 64'd0);
        check("seg_99999999", 64'(seg), 64'({8{7'b0010000}}));

        // 4. all ones
        value = 32'hFFFF_FFFF;
        tick(LATENCY + 1);
        check("ovf_max", 64'(overflow), 64'd1);
        check("seg_max", 64'(seg), 64'({7'b0010000, 7'b0011001, 7'b0010000, 7'b0000010,
                                        7'b1111000, 7'b0100100, 7'b0010000, 7'b0010010}));

        // 5. change while busy: 5 then 7 on the 10th shift edge
        value = 32'd5;
        tick(1);
        tick(10);
        value = 32'd7;
        tick(LATENCY - 10);
        check("seg_5_first", 64'(seg), 64'({B, B, B, B, B, B, B, 7'b0010010}));
        check("busy_after_5", 64'(busy), 64'd0);
        tick(1);
        check("busy_second", 64'(busy), 64'd1);
        tick(LATENCY);
        check("seg_7", 64'(seg), 64'({B, B, B, B, B, B, B, 7'b1111000}));

        // 6. reset in the middle of converting 999
        value = 32'd999;
        tick(1);
        tick(14);
        @(posedge clock);
        #2 resetn = 1'b0;
        #1;
        check("midreset_seg", 64'(seg), 64'({B, B, B, B, B, B, B, 7'b1000000}));
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_ovf", 64'(overflow), 64'd0);
        @(negedge clock);
        resetn = 1'b1;
        done = 1'b0;
        for (int i = 0; i < LATENCY + 3 && !done; i++) begin
            @(negedge clock);
            if (seg === {B, B, B, B, B, 7'b0010000, 7'b0010000, 7'b0010000} && !busy)
                done = 1'b1;
        end
        check("seg_999_after_reset", 64'(done), 64'd1);

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
